// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder in front of a word-organised on-chip SRAM.
//
// Each accepted transfer passes through WAIT_STATES wait cycles (HREADYOUT=0) and then
// one data cycle. Byte-lane writes commit on the data-phase edge. Reads are issued at
// the accept edge. A read accepted at the same edge as a write commit to the same word
// gets the write forwarded to it.
//
// Optional feature macro: AHB_SRAM_ERR_EN
//   When defined, a transfer is rejected with a two-cycle ERROR response if it is
//   oversized, misaligned or outside the memory range.
//   When undefined, HRESP is always 0 and out-of-range or misaligned addresses alias.
//
// Parameters:
//   ADDR_WIDTH   word-index width; the memory holds 2^ADDR_WIDTH 32-bit words.
//   WAIT_STATES  data-phase wait cycles per accepted transfer, 0..3.
//
// Ports:
//   HCLK, HRESETn                    clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS, HSIZE       address-phase controls
//   HWRITE, HREADY                   address-phase controls
//   HWDATA                           write data, sampled in the data cycle only
//   HRDATA, HREADYOUT, HRESP         registered responses

module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  localparam logic [1:0] WaitLoad = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  logic [31:0] mem [2**ADDR_WIDTH];

  state_e                state_q;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            mask_q;
  logic                  write_q;
  logic [31:0]           rbuf_q;

  logic                  accept;
  logic                  bad;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] new_idx;
  logic [3:0]            new_mask;
  logic [31:0]           lane_bits;
  logic [31:0]           wr_word;
  logic [31:0]           rd_word;

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign new_idx = HADDR[ADDR_WIDTH+1:2];

  // Little-endian lane select. HSIZE above word size is treated as a word.
  always_comb begin
    new_mask = 4'b1111;
    case (HSIZE)
      3'd0:    new_mask = 4'b0001 << HADDR[1:0];
      3'd1:    new_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: new_mask = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  assign bad = (HSIZE > 3'd2) ||
               ((HSIZE == 3'd1) && HADDR[0]) ||
               ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
               (HADDR[31:ADDR_WIDTH+2] != '0);
  logic unused;
  assign unused = HTRANS[0];
`else
  assign bad = 1'b0;
  logic unused;
  assign unused = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};
`endif

  assign lane_bits = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
  assign commit    = (state_q == StData) && write_q;
  assign wr_word   = (mem[idx_q] & ~lane_bits) | (HWDATA & lane_bits);
  // Forward a write that commits on the same edge as this read is accepted.
  assign rd_word   = (commit && (idx_q == new_idx)) ? wr_word : mem[new_idx];

  // A reset edge suppresses the commit, so a write in flight is discarded.
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit) begin
      mem[idx_q] <= wr_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      idx_q     <= '0;
      mask_q    <= 4'b0000;
      write_q   <= 1'b0;
      rbuf_q    <= 32'h0;
      HRDATA    <= 32'h0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      case (state_q)
        StWait: begin
          if (cnt_q == 2'd0) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
            // Read data stays buffered until the data cycle, so HRDATA holds its
            // previous value through the wait cycles.
            if (!write_q) begin
              HRDATA <= rbuf_q;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
`ifdef AHB_SRAM_ERR_EN
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
`endif
        // IDLE, DATA and ERR2 all complete on this edge and may accept a new transfer.
        default: begin
          if (accept) begin
            idx_q   <= new_idx;
            mask_q  <= new_mask;
            write_q <= HWRITE & ~bad;
            if (bad) begin
              state_q   <= StErr1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state_q   <= StWait;
              cnt_q     <= WaitLoad;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              if (!HWRITE) begin
                rbuf_q <= rd_word;
              end
            end else begin
              state_q   <= StData;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              if (!HWRITE) begin
                HRDATA <= rd_word;
              end
            end
          end else begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
module tb_ahb_sram_slave;

  localparam int unsigned AW = 12;
  localparam int          NW = 1 << AW;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hresetn   [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic [2:0]  hsize     [2];
  logic        hwrite    [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  int wait_cfg [2] = '{0, 2};

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(hresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(hresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    bit          write;
    logic [31:0] wdata;
    bit          lit_en;
    logic [31:0] lit;
  } txn_t;

  // Byte-addressed reference memory, one per instance.
  byte unsigned mdl     [2][NW*4];
  logic [31:0]  last_rd [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input bit w, input logic [31:0] a, input int sz,
                              input logic [31:0] wd, input bit le, input logic [31:0] lv);
    txn_t t;
    t.sel = 1'b1; t.trans = 2'b10; t.addr = a; t.size = 3'(sz);
    t.write = w; t.wdata = wd; t.lit_en = le; t.lit = lv;
    return t;
  endfunction

  function automatic bit is_bad(input txn_t t);
    if (!ErrEn) return 1'b0;
    return (t.size > 3'd2) || (t.size == 3'd1 && (t.addr % 2) != 0) ||
           (t.size == 3'd2 && (t.addr % 4) != 0) || (t.addr >= 32'(4 * NW));
  endfunction

  function automatic int base_byte(input txn_t t);
    return int'((t.addr / 4) % NW) * 4;
  endfunction

  function automatic bit lane_on(input txn_t t, input int lane);
    int off = int'(t.addr % 4);
    case (t.size)
      3'd0:    return lane == off;
      3'd1:    return (lane / 2) == (off / 2);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int d, input txn_t t);
    logic [31:0] v;
    int b = base_byte(t);
    for (int l = 0; l < 4; l++) v[8*l +: 8] = mdl[d][b+l];
    return v;
  endfunction

  function automatic void model_write(input int d, input txn_t t);
    int b = base_byte(t);
    for (int l = 0; l < 4; l++)
      if (lane_on(t, l)) mdl[d][b+l] = t.wdata[8*l +: 8];
  endfunction

  task automatic drive_addr(input int d, input txn_t t);
    hsel[d] = t.sel; htrans[d] = t.trans; haddr[d] = t.addr;
    hsize[d] = t.size; hwrite[d] = t.write;
  endtask

  task automatic drive_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = $urandom;
    hsize[d] = 3'd0; hwrite[d] = 1'b0;
  endtask

  // Pipelined master: the address phase of the next transfer overlaps the data phase
  // of the current one. Every data phase is scored against the sequential model.
  task automatic run(input int d, input txn_t q[$]);
    int ai = 0, di = -1, waits = 0, cyc = 0;
    int limit = 20 + 10 * q.size();
    bit act, bad;
    logic [31:0] rv;
    while (ai < q.size() || di >= 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        check("run_bound", 32'(cyc), 32'(limit));
        return;
      end
      if (ai < q.size()) drive_addr(d, q[ai]);
      else drive_idle(d);
      hwdata[d] = $urandom;  // garbage unless this is a write's data cycle
      if (di >= 0) begin
        act = q[di].sel && q[di].trans[1];
        bad = act && is_bad(q[di]);
        if (!hreadyout[d]) begin
          waits++;
          check("resp_in_wait", 32'(hresp[d]), 32'(bad));
          if (waits > 6) begin
            check("wait_bound", 32'(waits), 32'(6));
            return;
          end
        end else begin
          if (act && q[di].write) hwdata[d] = q[di].wdata;
          check("resp", 32'(hresp[d]), 32'(bad));
          check("waits", 32'(waits), !act ? 32'd0 : bad ? 32'd1 : 32'(wait_cfg[d]));
          if (act && !bad && !q[di].write) begin
            rv = model_read(d, q[di]);
            check("rdata", hrdata[d], rv);
            if (q[di].lit_en) check("rdata_lit", hrdata[d], q[di].lit);
            last_rd[d] = rv;
          end else begin
            check("rdata_hold", hrdata[d], last_rd[d]);
            if (act && !bad && q[di].write) model_write(d, q[di]);
          end
        end
      end else begin
        check("idle_ready", 32'(hreadyout[d]), 32'd1);
      end
      if (hreadyout[d]) begin
        di = (ai < q.size()) ? ai : -1;
        if (ai < q.size()) ai++;
        waits = 0;
      end
    end
  endtask

  task automatic test_instance(input int d);
    txn_t q[$];
    txn_t t;
    // Known contents for the words the random traffic touches.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 32'(4 * i), 2, $urandom, 1'b0, 32'h0));
    run(d, q);

    q = {};
    q.push_back(mk(1'b1, 32'h10, 2, 32'hDEADBEEF, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 32'h10, 2, 32'h0, 1'b1, 32'hDEADBEEF));
    q.push_back(mk(1'b1, 32'h10, 2, 32'h11223344, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 32'h13, 0, 32'hAAAAAAAA, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 32'h10, 2, 32'h0, 1'b1, 32'hAA223344));
    q.push_back(mk(1'b1, 32'h10, 1, 32'h55665566, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 32'h10, 2, 32'h0, 1'b1, 32'hAA225566));
    q.push_back(mk(1'b1, 32'h0, 2, 32'hCAFEF00D, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 32'h0, 2, 32'h0, 1'b1, 32'hCAFEF00D));
    q.push_back(mk(1'b0, 32'h4000, 2, 32'h0, !ErrEn, 32'hCAFEF00D));
    q.push_back(mk(1'b1, 32'h2, 2, 32'h01234567, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 32'h0, 2, 32'h0, 1'b0, 32'h0));
    t = mk(1'b1, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 32'h0);
    t.trans = 2'b00;
    q.push_back(t);
    t.trans = 2'b01;
    q.push_back(t);
    q.push_back(mk(1'b0, 32'h0, 2, 32'h0, 1'b0, 32'h0));
    run(d, q);

    q = {};
    for (int i = 0; i < 80; i++) begin
      t.sel    = ($urandom_range(0, 9) != 0);
      t.trans  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1))
                                             : 2'($urandom_range(2, 3));
      t.addr   = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) t.addr = t.addr | 32'h4000;
      t.size   = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      t.write  = 1'($urandom_range(0, 1));
      t.wdata  = $urandom;
      t.lit_en = 1'b0;
      t.lit    = 32'h0;
      q.push_back(t);
    end
    run(d, q);
  endtask

  initial begin
    txn_t q[$];
    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0;
      drive_idle(d);
      hwdata[d]  = 32'h0;
      last_rd[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    hresetn[0] = 1'b1;
    hresetn[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(hreadyout[d]), 32'd1);
      check("rst_resp", 32'(hresp[d]), 32'd0);
      check("rst_rdata", hrdata[d], 32'h0);
    end

    test_instance(0);
    test_instance(1);

    // Reset in the wait phase of a write to word 5: write must not commit.
    @(negedge clk);
    drive_addr(1, mk(1'b1, 32'h14, 2, 32'h0, 1'b0, 32'h0));
    hwdata[1] = $urandom;
    check("pre_rst_ready", 32'(hreadyout[1]), 32'd1);
    @(negedge clk);
    drive_idle(1);
    hwdata[1] = 32'h12345678;
    check("pre_rst_wait", 32'(hreadyout[1]), 32'd0);
    hresetn[1] = 1'b0;
    @(negedge clk);
    hresetn[1] = 1'b1;
    check("midrst_ready", 32'(hreadyout[1]), 32'd1);
    check("midrst_resp", 32'(hresp[1]), 32'd0);
    check("midrst_rdata", hrdata[1], 32'h0);
    last_rd[1] = 32'h0;
    q = {};
    q.push_back(mk(1'b0, 32'h14, 2, 32'h0, 1'b0, 32'h0));
    run(1, q);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder that fronts an on-chip word-organised SRAM for the Cortex-M0 master port. It decodes address and data phases, drives byte-lane writes and reads, inserts a configurable number of wait states, and optionally returns a two-cycle ERROR response. It sits behind the system AHB decoder as one slave on the HCLK bus.

## Interface

- ADDR_WIDTH, 12: word-index width; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0: data-phase wait cycles per accepted transfer, legal range 0..3.

- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  transfer address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are active.
- HSIZE  in  3  0 byte, 1 halfword, 2 word.
- HWRITE  in  1  1 write, 0 read.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation

- Accept: transfer accepted on an edge where HSEL & HREADY & HTRANS[1]. Capture word index HADDR[ADDR_WIDTH+1:2], byte mask, HWRITE.
- Byte mask (little-endian): size 0 -> lane HADDR[1:0]; size 1 -> lanes {HADDR[1],0} and {HADDR[1],1}; size 2 -> all four.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. Accepted good transfer -> WAIT if WAIT_STATES>0, else DATA. Accepted bad transfer -> ERR1 (only with macro).
- WAIT: HREADYOUT=0; counter loads WAIT_STATES-1 on entry, decrements; at 0 -> DATA.
- DATA: HREADYOUT=1, HRESP=0. Write: merged HWDATA bytes written to memory at this edge. A new transfer accepted at the same edge -> WAIT/DATA/ERR1 as from IDLE; otherwise -> IDLE.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2. ERR2: HREADYOUT=1, HRESP=1; no memory access; transfer accepted at this edge handled as from IDLE.
- Read: synchronous memory read issued at the accept edge; HRDATA holds result through DATA. Unselected byte lanes return the stored bytes (full word always driven).
- Read-after-write hazard: read accepted at the edge that commits a write to the same word returns the newly written bytes merged over old bytes (forwarding).
- IDLE/BUSY with HSEL=1: zero-wait OKAY, no access.
- HRDATA holds last value when not in a read data phase.

## Timing

- Reset (HRESETn=0 at an edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, pending write discarded. Memory contents not reset.
- Reset mid-transfer aborts it; a write in WAIT or DATA at the reset edge is not committed.
- Latency: accept edge + WAIT_STATES cycles with HREADYOUT=0, then one DATA cycle. WAIT_STATES=0 gives back-to-back single-cycle transfers.
- Write data sampled only on the DATA-state edge; HWDATA during WAIT ignored.
- ERROR always two cycles, HRESP=1 in both, HREADYOUT low then high.

## Configuration

- AHB_SRAM_ERR_EN defined: bad transfer = HSIZE>2, misaligned (size 1 with HADDR[0]=1, size 2 with HADDR[1:0]!=0), or HADDR[31:ADDR_WIDTH+2] != 0. Bad transfer -> ERR1/ERR2, no memory access.
- Undefined: ERR states absent, HRESP tied 0. Upper address bits ignored (aliasing), misaligned low bits ignored (aligned down), HSIZE>2 treated as word.

## Test plan

- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, read 0x10 next cycle -> HRDATA=0xDEADBEEF in data phase, HREADYOUT never low.
- Byte write 0xAA to 0x13 over 0x11223344 -> read 0x10 gives 0xAA223344; halfword 0x5566 to 0x10 -> 0xAA225566.
- WAIT_STATES=2: read -> exactly 2 cycles HREADYOUT=0, then data; HWDATA changed during waits does not affect a write.
- Back-to-back write 0x0 then read 0x0 accepted at the write commit edge -> read returns new data (forwarding).
- With AHB_SRAM_ERR_EN: word access at 0x2 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, memory unchanged; address 0x4000 with ADDR_WIDTH=12 -> ERROR. Without macro: 0x4000 aliases to 0x0, OKAY.
- Assert HRESETn=0 during WAIT of a write -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; target word unchanged.
